mult_div_unit: RTL

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage. It consumes the two register-file read operands (data1, data2) and produces HI/LO for the MFHI/MFLO writeback path. It also accepts MTHI/MTLO writes. It executes MULT, MULTU, DIV and DIVU with a fixed multi-cycle latency and a busy/done handshake toward the control unit.

---
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
//   MULTU/MULT use one radix-2 shift-add step per cycle on a 64-bit product
//   accumulator. DIVU/DIV use one restoring shift-subtract step per cycle.
//   Signed ops run on operand magnitudes, and the sign fixup is applied in
//   FINISH. Fixed latency: 1 accept + 32 steps + 1 finish.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | accepts start or MTHI/MTLO writes; start wins over writes
//   RUN    | 32 iteration steps; hi/lo are held
//   FINISH | sign fixup, hi/lo written, done pulses on the following cycle
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_start, i_op     request and opcode (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   i_a, i_b          operands, latched at start
//   i_wr_hi, i_wr_lo  MTHI/MTLO strobes, using i_wdata as the data
//   o_busy, o_done    operation in progress / one-cycle result-valid pulse
//   o_hi, o_lo        HI/LO registers
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_wr_hi,
  input  logic        i_wr_lo,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_count;
  logic        r_is_div;
  logic        r_neg_res;   // product / quotient gets negated
  logic        r_neg_rem;   // remainder gets negated (dividend was negative)
  logic        r_b_zero;
  logic [31:0] r_a;         // multiplicand, or dividend shifting into quotient
  logic [31:0] r_b;         // multiplier (shifts right), or divisor
  logic [31:0] r_rem;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_signed = i_op[0];
  assign w_a_mag  = (w_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
  assign w_b_mag  = (w_signed && i_b[31]) ? (32'd0 - i_b) : i_b;

  // Shift-add step: add the multiplicand into the upper half, and keep the carry as bit 63.
  assign w_sum = {1'b0, r_acc[63:32]} + {1'b0, (r_b[0] ? r_a : 32'd0)};

  // Restoring divide step. When w_ge holds, the true difference is below the divisor.
  // That means it fits in 32 bits, so a 32-bit subtract is exact.
  assign w_shift = {r_rem, r_a[31]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[31:0] - r_b;

  assign w_prod = r_neg_res ? (64'd0 - r_acc) : r_acc;
  assign w_quo  = r_b_zero ? 32'hFFFF_FFFF :
                  (r_neg_res ? (32'd0 - r_a) : r_a);
  // With a zero divisor the remainder ends up as |a|.
  // Re-applying the dividend sign therefore gives back the original a.
  assign w_rem  = r_neg_rem ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_RUN;
      S_RUN:    if (r_count == 5'd31) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 5'd0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b_zero  <= 1'b0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_rem     <= 32'd0;
      r_acc     <= 64'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_count   <= 5'd0;
            r_is_div  <= i_op[1];
            r_neg_res <= w_signed & (i_a[31] ^ i_b[31]);
            r_neg_rem <= w_signed & i_a[31];
            r_b_zero  <= i_op[1] & (i_b == 32'd0);
            r_a       <= w_a_mag;
            r_b       <= w_b_mag;
            r_rem     <= 32'd0;
            r_acc     <= 64'd0;
          end else begin
            if (i_wr_hi) r_hi <= i_wdata;
            if (i_wr_lo) r_lo <= i_wdata;
          end
        end
        S_RUN: begin
          r_count <= r_count + 5'd1;
          if (r_is_div) begin
            r_rem <= w_ge ? w_diff : w_shift[31:0];
            r_a   <= {r_a[30:0], w_ge};
          end else begin
            r_acc <= {w_sum, r_acc[31:1]};
            r_b   <= {1'b0, r_b[31:1]};
          end
        end
        S_FINISH: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
